// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort engine time-sharing one W-bit magnitude comparator; result words start (N-1)^2+1 cycles after the last load.
// No backpressure: din_valid gaps stall LOAD, and the N sorted words are emitted on consecutive cycles.
module cmp_sort_ctrl #(
   parameter int W   = 3,
   parameter int N   = 4,
   parameter int SCW = $clog2(N*(N-1)/2+1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   din,
   input  logic           din_valid,
   output logic           busy,
   output logic [W-1:0]   dout,
   output logic           dout_valid,
   output logic           done,
   output logic [SCW-1:0] swap_cnt
);

   localparam int IW = $clog2(N);
   localparam int EW = $clog2(N+1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N-1);
   localparam logic [IW-1:0] J_LAST   = IW'(N-2);
   localparam logic [EW-1:0] E_LAST   = EW'(N-1);
   localparam logic [EW-1:0] E_END    = EW'(N);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_EMIT} state_t;

   state_t           r_state;
   logic [W-1:0]     r_mem [N];
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    r_j;
   logic [IW-1:0]    r_p;
   logic [EW-1:0]    r_e;
   logic [SCW-1:0]   r_swap_cnt;
   logic             r_busy;
   logic [W-1:0]     r_dout;
   logic             r_dout_valid;
   logic             r_done;

   logic [IW-1:0]    w_j1;
   logic [W-1:0]     w_a;
   logic [W-1:0]     w_b;
   logic             w_gt;

   // Shared comparator always looks at the adjacent pair selected by r_j.
   assign w_j1 = r_j + IW'(1);
   assign w_a  = r_mem[r_j];
   assign w_b  = r_mem[w_j1];
   assign w_gt = (w_a > w_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         for (int i = 0; i < N; i++) r_mem[i] <= '0;
         r_idx        <= '0;
         r_j          <= '0;
         r_p          <= '0;
         r_e          <= '0;
         r_swap_cnt   <= '0;
         r_busy       <= 1'b0;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_LOAD;
                  r_idx      <= '0;
                  r_swap_cnt <= '0;
                  r_busy     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (din_valid) begin
                  r_mem[r_idx] <= din;
                  r_idx        <= r_idx + IW'(1);
                  if (r_idx == IDX_LAST) begin
                     r_state <= S_SORT;
                     r_j     <= '0;
                     r_p     <= '0;
                  end
               end
            end
            S_SORT: begin
               // Strictly greater swaps only, so equal keys keep their order.
               if (w_gt) begin
                  r_mem[r_j]  <= w_b;
                  r_mem[w_j1] <= w_a;
                  r_swap_cnt  <= r_swap_cnt + SCW'(1);
               end
               if (r_j == J_LAST) begin
                  r_j <= '0;
                  if (r_p == J_LAST) begin
                     r_state <= S_EMIT;
                     r_e     <= '0;
                  end else begin
                     r_p <= r_p + IW'(1);
                  end
               end else begin
                  r_j <= w_j1;
               end
            end
            S_EMIT: begin
               // Extra step at r_e==N keeps busy high alongside done.
               if (r_e != E_END) begin
                  r_dout       <= r_mem[r_e[IW-1:0]];
                  r_dout_valid <= 1'b1;
                  r_done       <= (r_e == E_LAST);
                  r_e          <= r_e + EW'(1);
               end else begin
                  r_dout_valid <= 1'b0;
                  r_done       <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign done       = r_done;
   assign swap_cnt   = r_swap_cnt;

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Bench for cmp_sort_ctrl: directed and random jobs against a sort/inversion-count reference.
module tb_cmp_sort_ctrl;

   localparam int W   = 3;
   localparam int N   = 4;
   localparam int SCW = $clog2(N*(N-1)/2+1);
   localparam int LAT = (N-1)*(N-1) + 1;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   din;
   logic           din_valid;
   logic           busy;
   logic [W-1:0]   dout;
   logic           dout_valid;
   logic           done;
   logic [SCW-1:0] swap_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   cmp_sort_ctrl #(.W(W), .N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .din        (din),
      .din_valid  (din_valid),
      .busy       (busy),
      .dout       (dout),
      .dout_valid (dout_valid),
      .done       (done),
      .swap_cnt   (swap_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Bubble sort performs exactly one swap per inverted pair.
   function automatic int inversions(input logic [W-1:0] w [N]);
      int s = 0;
      for (int i = 0; i < N; i++)
         for (int k = i + 1; k < N; k++)
            if (w[i] > w[k]) s++;
      return s;
   endfunction

   task automatic start_and_load(input logic [W-1:0] w [N], input int g [N], output int acc);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_start", busy, 1);
      chk("cnt_clear", swap_cnt, 0);
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < g[i]; k++) begin
            @(posedge clk); #1;
            chk("busy_load", busy, 1);
         end
         din       = w[i];
         din_valid = 1'b1;
         @(posedge clk); #1;
         din_valid = 1'b0;
      end
      acc = cyc;
   endtask

   task automatic run_job(input logic [W-1:0] w [N], input int g [N], input bit inj);
      int exp_q[$];
      int exp_sw;
      int acc;
      int n;
      foreach (w[i]) exp_q.push_back(int'(w[i]));
      exp_q.sort();
      exp_sw = inversions(w);
      start_and_load(w, g, acc);
      n = 0;
      for (int c = 0; c < 40 && n < N; c++) begin
         if (inj) begin
            start     = 1'($urandom_range(0, 1));
            din_valid = 1'($urandom_range(0, 1));
            din       = '1;
         end
         @(posedge clk); #1;
         chk("busy_run", busy, 1);
         if (dout_valid) begin
            if (n == 0) chk("latency", cyc - acc, LAT);
            chk("dout", dout, exp_q[n]);
            chk("done_pos", done, int'(n == N-1));
            n++;
         end else begin
            chk("done_idle", done, 0);
         end
      end
      // start coincident with done must be ignored.
      start     = 1'b1;
      din_valid = 1'b0;
      chk("emit_count", n, N);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_end", busy, 0);
      chk("valid_end", dout_valid, 0);
      chk("done_end", done, 0);
      chk("swap_cnt", swap_cnt, exp_sw);
      chk("dout_hold", dout, exp_q[N-1]);
      @(posedge clk); #1;
      chk("start_ignored", busy, 0);
      chk("swap_hold", swap_cnt, exp_sw);
   endtask

   task automatic reset_mid_sort();
      int acc;
      start_and_load('{7, 6, 5, 4}, '{0, 0, 0, 0}, acc);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("mid_cnt", swap_cnt, 4);
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", swap_cnt, 0);
      chk("rst_dout", dout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [W-1:0] rw [N];
      int           rg [N];
      rst_n     = 1'b0;
      start     = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_dout", dout, 0);
      chk("reset_valid", dout_valid, 0);
      chk("reset_done", done, 0);
      chk("reset_cnt", swap_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_job('{5, 1, 7, 3}, '{0, 0, 0, 0}, 1'b0);
      run_job('{7, 6, 5, 4}, '{0, 0, 0, 0}, 1'b0);
      run_job('{2, 2, 0, 2}, '{0, 0, 0, 0}, 1'b0);
      run_job('{0, 1, 2, 3}, '{0, 0, 2, 1}, 1'b0);
      run_job('{5, 1, 7, 3}, '{0, 0, 0, 0}, 1'b1);
      reset_mid_sort();
      run_job('{3, 0, 2, 1}, '{0, 0, 0, 0}, 1'b0);

      for (int t = 0; t < 16; t++) begin
         for (int i = 0; i < N; i++) begin
            rw[i] = W'($urandom_range(0, (1 << W) - 1));
            rg[i] = int'($urandom_range(0, 2));
         end
         run_job(rw, rg, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
